// File: rtl/cache_ctrl_pkg.sv
// Definitions shared by cache_ctrl and the memory bus it talks to:
// bus widths and the IDEL/RD/WT command codes.
package cache_ctrl_pkg;

    localparam int unsigned ADDRWIDTH    = 16;
    localparam int unsigned WORDWIDTH    = 16;
    localparam int unsigned IOSTATEWIDTH = 2;

    localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd0;
    localparam logic [IOSTATEWIDTH-1:0] RD   = 2'd1;
    localparam logic [IOSTATEWIDTH-1:0] WT   = 2'd2;

    // Code 2'd3 is not a request and behaves like IDEL.
    function automatic logic is_req(input logic [IOSTATEWIDTH-1:0] rw);
        return (rw == RD) || (rw == WT);
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Processor-side and memory-bus-side signals of one cache controller.
// master is the controller's view; slave is the processor/bus environment's view.
interface cache_ctrl_if;
    import cache_ctrl_pkg::*;

    logic [IOSTATEWIDTH-1:0] rwFromCpu;
    logic [ADDRWIDTH-1:0]    addrFromCpu;
    logic [WORDWIDTH-1:0]    dataFromCpu;
    logic [WORDWIDTH-1:0]    dataToCpu;
    logic                    readyToCpu;

    logic [IOSTATEWIDTH-1:0] rwToBus;
    logic [ADDRWIDTH-1:0]    addrToBus;
    logic [WORDWIDTH-1:0]    dataToBus;
    logic [WORDWIDTH-1:0]    dataFromBus;
    logic                    rdEnFromBus;
    logic                    wbDoneFromBus;

    modport master (
        input  rwFromCpu, addrFromCpu, dataFromCpu, dataFromBus, rdEnFromBus, wbDoneFromBus,
        output dataToCpu, readyToCpu, rwToBus, addrToBus, dataToBus
    );

    modport slave (
        output rwFromCpu, addrFromCpu, dataFromCpu, dataFromBus, rdEnFromBus, wbDoneFromBus,
        input  dataToCpu, readyToCpu, rwToBus, addrToBus, dataToBus
    );

endinterface

// File: rtl/cache_line_array.sv
// Line storage for a direct-mapped cache: valid/dirty/tag/data per index,
// one synchronous write port, combinational read, reset clears valid and dirty.
module cache_line_array #(
    parameter int unsigned INDEXWIDTH = 4,
    parameter int unsigned TAGWIDTH   = 12,
    parameter int unsigned WORDWIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [INDEXWIDTH-1:0] i_widx,
    input  logic [TAGWIDTH-1:0]   i_wtag,
    input  logic [WORDWIDTH-1:0]  i_wdata,
    input  logic                  i_wvalid,
    input  logic                  i_wdirty,
    input  logic [INDEXWIDTH-1:0] i_ridx,
    output logic                  o_valid,
    output logic                  o_dirty,
    output logic [TAGWIDTH-1:0]   o_tag,
    output logic [WORDWIDTH-1:0]  o_data
);

    localparam int unsigned LINES = 1 << INDEXWIDTH;

    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    logic [TAGWIDTH-1:0]  r_tag  [LINES];
    logic [WORDWIDTH-1:0] r_data [LINES];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= i_wvalid;
            r_dirty[i_widx] <= i_wdirty;
        end
    end

    // Reset has priority so an aborted fill never lands in the array.
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_dirty = r_dirty[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 controller, one word per line.
// Define CACHE_STATS_EN to add saturating hitCount/missCount outputs.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned INDEXWIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    cache_ctrl_if.master io_cc
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]  hitCount,
    output logic [15:0]  missCount
`endif
);

    localparam int unsigned TAGWIDTH = ADDRWIDTH - INDEXWIDTH;

    typedef enum logic [2:0] {S_IDLE, S_CMP, S_WB, S_GAP, S_FILL, S_DONE} state_t;

    state_t                  r_state, w_state_next;
    logic                    r_is_write, w_is_write_next;
    logic [ADDRWIDTH-1:0]    r_addr, w_addr_next;
    logic [WORDWIDTH-1:0]    r_data, w_data_next;
    logic [WORDWIDTH-1:0]    r_data_to_cpu, w_data_to_cpu_next;
    logic                    r_ready, w_ready_next;
    logic [IOSTATEWIDTH-1:0] r_rw_bus, w_rw_bus_next;
    logic [ADDRWIDTH-1:0]    r_addr_bus, w_addr_bus_next;
    logic [WORDWIDTH-1:0]    r_data_bus, w_data_bus_next;

    logic [INDEXWIDTH-1:0]   w_index;
    logic [TAGWIDTH-1:0]     w_tag;
    logic                    w_line_valid, w_line_dirty, w_hit;
    logic [TAGWIDTH-1:0]     w_line_tag;
    logic [WORDWIDTH-1:0]    w_line_data;
    logic                    w_we, w_wvalid, w_wdirty;
    logic [TAGWIDTH-1:0]     w_wtag;
    logic [WORDWIDTH-1:0]    w_wdata;

    assign w_index = r_addr[INDEXWIDTH-1:0];
    assign w_tag   = r_addr[ADDRWIDTH-1:INDEXWIDTH];
    assign w_hit   = w_line_valid && (w_line_tag == w_tag);

    cache_line_array #(
        .INDEXWIDTH (INDEXWIDTH),
        .TAGWIDTH   (TAGWIDTH),
        .WORDWIDTH  (WORDWIDTH)
    ) u_lines (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_we     (w_we),
        .i_widx   (w_index),
        .i_wtag   (w_wtag),
        .i_wdata  (w_wdata),
        .i_wvalid (w_wvalid),
        .i_wdirty (w_wdirty),
        .i_ridx   (w_index),
        .o_valid  (w_line_valid),
        .o_dirty  (w_line_dirty),
        .o_tag    (w_line_tag),
        .o_data   (w_line_data)
    );

    always_comb begin
        w_state_next       = r_state;
        w_is_write_next    = r_is_write;
        w_addr_next        = r_addr;
        w_data_next        = r_data;
        w_data_to_cpu_next = r_data_to_cpu;
        w_ready_next       = 1'b0;
        w_rw_bus_next      = r_rw_bus;
        w_addr_bus_next    = r_addr_bus;
        w_data_bus_next    = r_data_bus;
        // Array writes default to rewriting the current line unchanged.
        w_we               = 1'b0;
        w_wvalid           = w_line_valid;
        w_wdirty           = w_line_dirty;
        w_wtag             = w_line_tag;
        w_wdata            = w_line_data;

        unique case (r_state)
            S_IDLE: begin
                if (is_req(io_cc.rwFromCpu)) begin
                    w_is_write_next = (io_cc.rwFromCpu == WT);
                    w_addr_next     = io_cc.addrFromCpu;
                    w_data_next     = io_cc.dataFromCpu;
                    w_state_next    = S_CMP;
                end
            end
            S_CMP: begin
                if (w_hit) begin
                    w_ready_next = 1'b1;
                    w_state_next = S_DONE;
                    if (r_is_write) begin
                        w_we     = 1'b1;
                        w_wdata  = r_data;
                        w_wdirty = 1'b1;
                    end else begin
                        w_data_to_cpu_next = w_line_data;
                    end
                end else if (w_line_valid && w_line_dirty) begin
                    w_rw_bus_next   = WT;
                    w_addr_bus_next = {w_line_tag, w_index};
                    w_data_bus_next = w_line_data;
                    w_state_next    = S_WB;
                end else begin
                    w_rw_bus_next   = RD;
                    w_addr_bus_next = r_addr;
                    w_state_next    = S_FILL;
                end
            end
            S_WB: begin
                if (io_cc.wbDoneFromBus) begin
                    w_we          = 1'b1;
                    w_wdirty      = 1'b0;
                    w_rw_bus_next = IDEL;
                    w_state_next  = S_GAP;
                end
            end
            S_GAP: begin
                w_rw_bus_next   = RD;
                w_addr_bus_next = r_addr;
                w_state_next    = S_FILL;
            end
            S_FILL: begin
                if (io_cc.rdEnFromBus) begin
                    w_we          = 1'b1;
                    w_wvalid      = 1'b1;
                    w_wdirty      = 1'b0;
                    w_wtag        = w_tag;
                    w_wdata       = io_cc.dataFromBus;
                    w_rw_bus_next = IDEL;
                    w_state_next  = S_CMP;
                end
            end
            S_DONE: begin
                if (!is_req(io_cc.rwFromCpu)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_is_write    <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_data_to_cpu <= '0;
            r_ready       <= 1'b0;
            r_rw_bus      <= IDEL;
            r_addr_bus    <= '0;
            r_data_bus    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_is_write    <= w_is_write_next;
            r_addr        <= w_addr_next;
            r_data        <= w_data_next;
            r_data_to_cpu <= w_data_to_cpu_next;
            r_ready       <= w_ready_next;
            r_rw_bus      <= w_rw_bus_next;
            r_addr_bus    <= w_addr_bus_next;
            r_data_bus    <= w_data_bus_next;
        end
    end

    assign io_cc.dataToCpu  = r_data_to_cpu;
    assign io_cc.readyToCpu = r_ready;
    assign io_cc.rwToBus    = r_rw_bus;
    assign io_cc.addrToBus  = r_addr_bus;
    assign io_cc.dataToBus  = r_data_bus;

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;
    logic        r_refill;

    // r_refill marks the re-compare right after a fill so it is not counted as a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_refill   <= 1'b0;
        end else begin
            if (r_state == S_CMP) begin
                if (w_hit && !r_refill && (r_hit_cnt != 16'hFFFF)) begin
                    r_hit_cnt <= r_hit_cnt + 16'd1;
                end
                if (!w_hit && (r_miss_cnt != 16'hFFFF)) begin
                    r_miss_cnt <= r_miss_cnt + 16'd1;
                end
            end
            r_refill <= (r_state == S_FILL) && io_cc.rdEnFromBus;
        end
    end

    assign hitCount  = r_hit_cnt;
    assign missCount = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: a direct-mapped reference model predicts bus
// transactions and CPU responses; bus responder and CPU monitor check them.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0]  rw;
        logic [15:0] addr;
        logic [15:0] data;
    } bus_txn_t;

    typedef struct packed {
        logic        is_read;
        logic [15:0] data;
        logic [7:0]  lat;
    } cpu_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int req_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    cache_ctrl_if cc_if ();

    logic        resp_rd, resp_wb, spur_rd, spur_wb, bus_stall;
    logic [15:0] resp_data, spur_data;

    assign cc_if.rdEnFromBus   = resp_rd | spur_rd;
    assign cc_if.wbDoneFromBus = resp_wb | spur_wb;
    assign cc_if.dataFromBus   = spur_rd ? spur_data : resp_data;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    cache_ctrl #(
        .INDEXWIDTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_cc (cc_if)
`ifdef CACHE_STATS_EN
        ,
        .hitCount  (hit_count),
        .missCount (miss_count)
`endif
    );

    // Reference model: backing memory plus a direct-mapped line table.
    logic [15:0] mem [0:65535];
    logic        m_valid [16];
    logic        m_dirty [16];
    logic [11:0] m_tag   [16];
    logic [15:0] m_data  [16];
    int          m_hits, m_misses;

    bus_txn_t q_bus[$];
    cpu_exp_t q_cpu[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    task automatic predict(input logic is_wr, input logic [15:0] addr, input logic [15:0] data);
        logic [3:0]  idx;
        logic [11:0] tag;
        logic        hit;
        logic [15:0] vaddr;
        cpu_exp_t    e;
        idx = addr[3:0];
        tag = addr[15:4];
        hit = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                vaddr = {m_tag[idx], idx};
                q_bus.push_back({WT, vaddr, m_data[idx]});
                mem[vaddr] = m_data[idx];
            end
            q_bus.push_back({RD, addr, 16'h0000});
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            m_data[idx]  = mem[addr];
        end
        if (is_wr) begin
            m_data[idx]  = data;
            m_dirty[idx] = 1'b1;
        end
        e.is_read = !is_wr;
        e.data    = m_data[idx];
        e.lat     = hit ? 8'd2 : 8'd0;
        q_cpu.push_back(e);
    endtask

    task automatic issue(input logic is_wr, input logic [15:0] addr, input logic [15:0] data);
        predict(is_wr, addr, data);
        req_cyc = cyc;
        cc_if.rwFromCpu   = is_wr ? WT : RD;
        cc_if.addrFromCpu = addr;
        cc_if.dataFromCpu = data;
    endtask

    // Latched copies must be used: address and data are scrambled once the request is taken.
    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!cc_if.readyToCpu && n < budget) begin
            cc_if.addrFromCpu = 16'($urandom);
            cc_if.dataFromCpu = 16'($urandom);
            @(negedge clk);
            n++;
        end
        if (!cc_if.readyToCpu) begin
            fail_now("ready_timeout");
        end
        cc_if.rwFromCpu = ($urandom_range(0, 1) == 1) ? 2'd3 : IDEL;
    endtask

    task automatic run_req(input logic is_wr, input logic [15:0] addr, input logic [15:0] data);
        issue(is_wr, addr, data);
        wait_ready(200);
        @(negedge clk);
    endtask

    task automatic wait_bus(input logic [1:0] code, input string name);
        int n;
        n = 0;
        while (cc_if.rwToBus != code && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(cc_if.rwToBus), 32'(code));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cc_if.rwFromCpu = IDEL;
        @(negedge clk);
        check("rst_rwToBus", 32'(cc_if.rwToBus), 32'(IDEL));
        check("rst_readyToCpu", 32'(cc_if.readyToCpu), 32'd0);
        check("rst_dataToCpu", 32'(cc_if.dataToCpu), 32'd0);
        check("rst_addrToBus", 32'(cc_if.addrToBus), 32'd0);
        check("rst_dataToBus", 32'(cc_if.dataToBus), 32'd0);
        q_bus.delete();
        q_cpu.delete();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // CPU-side monitor.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && cc_if.readyToCpu) begin
                if (q_cpu.size() == 0) begin
                    fail_now("unexpected_ready");
                end else begin
                    e = q_cpu.pop_front();
                    if (e.is_read) check("read_data", 32'(cc_if.dataToCpu), 32'(e.data));
                    if (e.lat != 0) check("hit_latency", 32'(cyc - req_cyc), 32'(e.lat));
                end
            end
        end
    end

    // Bus responder: checks each transaction against the model and answers after a random delay.
    initial begin
        bus_txn_t exp_t, cap;
        int       cnt, after_wt;
        logic     busy;
        busy = 1'b0;
        cnt = 0;
        after_wt = 0;
        cap = '0;
        resp_rd = 1'b0;
        resp_wb = 1'b0;
        resp_data = '0;
        forever begin
            @(negedge clk);
            resp_rd   = 1'b0;
            resp_wb   = 1'b0;
            resp_data = 16'($urandom);
            if (reset) begin
                busy = 1'b0;
                after_wt = 0;
                continue;
            end
            if (after_wt == 2) begin
                check("gap_idle", 32'(cc_if.rwToBus), 32'(IDEL));
                after_wt = 1;
            end else if (after_wt == 1) begin
                check("gap_then_rd", 32'(cc_if.rwToBus), 32'(RD));
                after_wt = 0;
            end
            if (busy) begin
                check("bus_hold_rw", 32'(cc_if.rwToBus), 32'(cap.rw));
                check("bus_hold_addr", 32'(cc_if.addrToBus), 32'(cap.addr));
                if (cap.rw == WT) check("bus_hold_data", 32'(cc_if.dataToBus), 32'(cap.data));
            end else if (cc_if.rwToBus == RD || cc_if.rwToBus == WT) begin
                if (q_bus.size() == 0) begin
                    fail_now("unexpected_bus_txn");
                end else begin
                    exp_t = q_bus.pop_front();
                    check("bus_cmd", 32'(cc_if.rwToBus), 32'(exp_t.rw));
                    check("bus_addr", 32'(cc_if.addrToBus), 32'(exp_t.addr));
                    if (exp_t.rw == WT) check("wb_data", 32'(cc_if.dataToBus), 32'(exp_t.data));
                end
                cap  = {cc_if.rwToBus, cc_if.addrToBus, cc_if.dataToBus};
                busy = 1'b1;
                cnt  = int'($urandom_range(0, 3));
            end
            if (busy && !bus_stall) begin
                if (cnt == 0) begin
                    if (cap.rw == RD) begin
                        resp_data = mem[cap.addr];
                        resp_rd   = 1'b1;
                    end else begin
                        resp_wb  = 1'b1;
                        after_wt = 2;
                    end
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503) ^ 16'hA5C3;
        mem[16'h0012] = 16'hBEEF;
        mem[16'h0105] = 16'h1111;
        cc_if.rwFromCpu   = IDEL;
        cc_if.addrFromCpu = '0;
        cc_if.dataFromCpu = '0;
        spur_rd   = 1'b0;
        spur_wb   = 1'b0;
        spur_data = '0;
        bus_stall = 1'b0;
        @(negedge clk);
        do_reset();

        // Cold read fill, then repeat as a hit.
        run_req(1'b0, 16'h0012, 16'h0000);
        check("plan_fill_data", 32'(cc_if.dataToCpu), 32'h0000BEEF);
        run_req(1'b0, 16'h0012, 16'h0000);

        // Write hit, then a conflicting read forces write-back of the CPU data.
        run_req(1'b1, 16'h0012, 16'h1234);
        run_req(1'b0, 16'h0022, 16'h0000);

        // Write miss on a clean line, then conflict writes back CPU data, not fill data.
        run_req(1'b1, 16'h0105, 16'h5A5A);
        run_req(1'b0, 16'h0205, 16'h0000);

        // Spurious wbDone while idle must not disturb the next hit.
        spur_wb = 1'b1;
        @(negedge clk);
        spur_wb = 1'b0;
        @(negedge clk);
        run_req(1'b0, 16'h0022, 16'h0000);

        // Spurious rdEn during a stalled write-back is ignored.
        run_req(1'b1, 16'h0205, 16'h7777);
        bus_stall = 1'b1;
        issue(1'b0, 16'h0305, 16'h0000);
        wait_bus(WT, "wb_started");
        spur_data = 16'hDEAD;
        spur_rd   = 1'b1;
        @(negedge clk);
        spur_rd = 1'b0;
        repeat (3) @(negedge clk);
        check("wb_still_wt", 32'(cc_if.rwToBus), 32'(WT));
        check("wb_still_addr", 32'(cc_if.addrToBus), 32'h00000205);
        bus_stall = 1'b0;
        wait_ready(200);
        @(negedge clk);
        run_req(1'b0, 16'h0205, 16'h0000);

        // Reset in the middle of a fill aborts it; the old line is gone afterwards.
        bus_stall = 1'b1;
        issue(1'b0, 16'h0033, 16'h0000);
        wait_bus(RD, "fill_started");
        do_reset();
        bus_stall = 1'b0;
        @(negedge clk);
        run_req(1'b0, 16'h0012, 16'h0000);

        // One miss followed by three hits.
        do_reset();
        run_req(1'b0, 16'h0040, 16'h0000);
        run_req(1'b0, 16'h0040, 16'h0000);
        run_req(1'b1, 16'h0040, 16'hCAFE);
        run_req(1'b0, 16'h0040, 16'h0000);
`ifdef CACHE_STATS_EN
        check("stats_hits", 32'(hit_count), 32'd3);
        check("stats_misses", 32'(miss_count), 32'd1);
`endif

        // Randomized traffic over a few tags per index to get hits, clean and dirty misses.
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            else a = {10'h000, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_req(($urandom_range(0, 1) == 1), a, 16'($urandom));
        end

        repeat (5) @(negedge clk);
        check("bus_queue_empty", 32'(q_bus.size()), 32'd0);
        check("cpu_queue_empty", 32'(q_cpu.size()), 32'd0);
`ifdef CACHE_STATS_EN
        check("stats_hits_final", 32'(hit_count), 32'(m_hits));
        check("stats_misses_final", 32'(miss_count), 32'(m_misses));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
